// File: rtl/macro_adder_pipe.sv
// LANES independent ripple-carry adder lanes behind a 2-stage valid/ready pipeline.
// Each beat either adds A+B per lane or accumulates ACC+A per lane.
module macro_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2
) (
`ifdef USE_POWER_PINS
  inout  wire                      VPWR,
  inout  wire                      VGND,
`endif
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode_i,
  input  logic                     acc_clr_i,
  input  logic [LANES*WIDTH-1:0]   a_i,
  input  logic [LANES*WIDTH-1:0]   b_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   sum_o,
  output logic [LANES-1:0]         carry_o,
  output logic                     carry_all_o
);

  // Stage 1 operand registers
  logic                     r_s1_valid;
  logic                     r_s1_mode;
  logic [LANES*WIDTH-1:0]   r_s1_a;
  logic [LANES*WIDTH-1:0]   r_s1_b;

  // Stage 2 (output) registers and lane accumulators
  logic                     r_out_valid;
  logic [LANES*WIDTH-1:0]   r_sum;
  logic [LANES-1:0]         r_carry;
  logic                     r_carry_all;
  logic [LANES*WIDTH-1:0]   r_acc;

  logic                     w_s2_ready;
  logic                     w_s2_load;
  logic                     w_in_fire;
  logic [LANES*WIDTH-1:0]   w_op_x;
  logic [LANES*WIDTH-1:0]   w_op_y;
  logic [LANES*WIDTH-1:0]   w_sum;
  logic [LANES-1:0]         w_carry;
  logic [WIDTH:0]           w_chain [LANES];

  assign w_s2_ready = !r_out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_s2_load  = r_s1_valid && w_s2_ready;

  // Operand select; a clear coincident with an accumulate load feeds ACC=0 into the add
  always_comb begin
    w_op_x = '0;
    w_op_y = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_s1_mode) begin
        w_op_x[k*WIDTH +: WIDTH] = acc_clr_i ? '0 : r_acc[k*WIDTH +: WIDTH];
        w_op_y[k*WIDTH +: WIDTH] = r_s1_a[k*WIDTH +: WIDTH];
      end else begin
        w_op_x[k*WIDTH +: WIDTH] = r_s1_a[k*WIDTH +: WIDTH];
        w_op_y[k*WIDTH +: WIDTH] = r_s1_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Bit-level ripple carry per lane; chain restarts at zero in every lane
  always_comb begin
    w_sum   = '0;
    w_carry = '0;
    w_chain = '{default: '0};
    for (int k = 0; k < LANES; k++) begin
      w_chain[k][0] = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        w_sum[k*WIDTH + i] = w_op_x[k*WIDTH + i] ^ w_op_y[k*WIDTH + i] ^ w_chain[k][i];
        w_chain[k][i+1]    = (w_op_x[k*WIDTH + i] & w_op_y[k*WIDTH + i]) |
                             (w_chain[k][i] & (w_op_x[k*WIDTH + i] ^ w_op_y[k*WIDTH + i]));
      end
      w_carry[k] = w_chain[k][WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_mode  <= mode_i;
      r_s1_a     <= a_i;
      r_s1_b     <= b_i;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= '0;
      r_carry_all <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_sum;
      r_carry     <= w_carry;
      r_carry_all <= &w_carry;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // An accumulate load wins over a plain clear: its sum already assumed ACC=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_s2_load && r_s1_mode) begin
      r_acc <= w_sum;
    end else if (acc_clr_i) begin
      r_acc <= '0;
    end
  end

  assign out_valid   = r_out_valid;
  assign sum_o       = r_sum;
  assign carry_o     = r_carry;
  assign carry_all_o = r_carry_all;

endmodule

// File: tb/tb_macro_adder_pipe.sv
// Directed self-checking bench for macro_adder_pipe (WIDTH=16, LANES=2).
module tb_macro_adder_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LANES = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mode_i;
  logic                   acc_clr_i;
  logic [LANES*WIDTH-1:0] a_i;
  logic [LANES*WIDTH-1:0] b_i;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] sum_o;
  logic [LANES-1:0]       carry_o;
  logic                   carry_all_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Captured results: {carry_all, carry[1:0], sum[31:0]}
  logic [34:0] q[$];

  always #5 clk = ~clk;

`ifdef USE_POWER_PINS
  wire vpwr = 1'b1;
  wire vgnd = 1'b0;
`endif

  macro_adder_pipe #(.WIDTH(WIDTH), .LANES(LANES)) dut (
`ifdef USE_POWER_PINS
    .VPWR        (vpwr),
    .VGND        (vgnd),
`endif
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode_i      (mode_i),
    .acc_clr_i   (acc_clr_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum_o       (sum_o),
    .carry_o     (carry_o),
    .carry_all_o (carry_all_o)
  );

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) q.push_back({carry_all_o, carry_o, sum_o});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until it transfers (in_ready sampled at the edge)
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m);
    logic took;
    int   n;
    in_valid = 1'b1;
    a_i      = a;
    b_i      = b;
    mode_i   = m;
    took     = 1'b0;
    n        = 0;
    while (!took && n < 50) begin
      @(posedge clk);
      took = in_ready;
      #1;
      n++;
    end
    n_checks++;
    if (!took) begin
      n_fail++;
      $display("FAIL send_accept: beat a=%h not accepted within 50 cycles", a);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int cnt);
    int n;
    n = 0;
    while (q.size() < cnt && n < 40) begin
      step(1);
      n++;
    end
    n_checks++;
    if (q.size() < cnt) begin
      n_fail++;
      $display("FAIL result_count: got %0d results, required %0d", q.size(), cnt);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || sum_o !== 32'h0 || carry_o !== 2'b00 || carry_all_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b sum=%h carry=%b all=%b, required 0", out_valid,
               sum_o, carry_o, carry_all_o);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    // Fill both stages with out_ready low, then reset mid-stream
    q.delete();
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    send(32'hFFFF_FFFF, 32'h0001_0001, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_full: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum_o !== 32'h0 || carry_o !== 2'b00 || carry_all_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out_valid=%b sum=%h carry=%b all=%b, required 0", out_valid,
               sum_o, carry_o, carry_all_o);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    step(1);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
    step(5);
    n_checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stale: %0d beats emitted, out_valid=%b, required 0/0", q.size(),
               out_valid);
    end
  endtask

  task automatic test_mode0();
    q.delete();
    out_ready = 1'b1;
    send(32'hFFFF_0001, 32'h0001_0001, 1'b0);
    // Transfer edge loads S1; result appears after the following edge
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_early: out_valid=%b right after accept, required 0", out_valid);
    end
    step(1);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mode0_latency: out_valid=%b, required 1", out_valid);
    end
    n_checks++;
    if (sum_o !== 32'h0000_0002 || carry_o !== 2'b10 || carry_all_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_result: sum=%h carry=%b all=%b, required 00000002/10/0", sum_o,
               carry_o, carry_all_o);
    end
    step(1);
    n_checks++;
    if (out_valid !== 1'b0 || q.size() != 1) begin
      n_fail++;
      $display("FAIL mode0_single: out_valid=%b results=%0d, required 0/1", out_valid, q.size());
    end
  endtask

  task automatic test_both_carry();
    q.delete();
    send(32'h8000_8000, 32'h8000_8000, 1'b0);
    wait_results(1);
    n_checks++;
    if (q.size() > 0 && q[0] !== {1'b1, 2'b11, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL both_carry: got %h required %h", q[0], {1'b1, 2'b11, 32'h0000_0000});
    end
  endtask

  task automatic test_accumulate();
    logic [34:0] exp [4];
    exp[0] = {1'b0, 2'b00, 32'h0001_4000};
    exp[1] = {1'b0, 2'b00, 32'h0002_8000};
    exp[2] = {1'b0, 2'b00, 32'h0003_C000};
    exp[3] = {1'b0, 2'b01, 32'h0004_0000};
    q.delete();
    acc_clr_i = 1'b1;
    step(1);
    acc_clr_i = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h0001_4000, 32'hDEAD_BEEF, 1'b1);
    wait_results(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i < q.size() && q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL accumulate_%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] av  [5];
    logic [34:0] exp [5];
    av[0] = 32'h1000_FFFE; exp[0] = {1'b0, 2'b00, 32'h1010_FFFF};
    av[1] = 32'h1001_FFFF; exp[1] = {1'b0, 2'b01, 32'h1011_0000};
    av[2] = 32'h1002_0000; exp[2] = {1'b0, 2'b00, 32'h1012_0001};
    av[3] = 32'h1003_0001; exp[3] = {1'b0, 2'b00, 32'h1013_0002};
    av[4] = 32'h1004_0002; exp[4] = {1'b0, 2'b00, 32'h1014_0003};
    q.delete();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) send(av[i], 32'h0010_0001, 1'b0);
      end
      begin
        logic [31:0] held;
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
          step(1);
          n++;
        end
        out_ready = 1'b0;
        held      = sum_o;
        step(3);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_ready: in_ready=%b out_valid=%b, required 0/1", in_ready,
                   out_valid);
        end
        n_checks++;
        if (sum_o !== held) begin
          n_fail++;
          $display("FAIL stall_hold: sum=%h changed, required %h", sum_o, held);
        end
        out_ready = 1'b1;
      end
    join
    wait_results(5);
    step(4);
    n_checks++;
    if (q.size() != 5) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results required 5", q.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i < q.size() && q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL bp_order_%0d: got %h required %h", i, q[i], exp[i]);
      end
    end
  endtask

  task automatic test_clr_collision();
    q.delete();
    out_ready = 1'b1;
    acc_clr_i = 1'b1;
    step(1);
    acc_clr_i = 1'b0;
    send(32'h0000_0005, 32'h0, 1'b1);
    wait_results(1);
    // Beat sits in S1; the next edge is its S2 load, coincident with the clear
    send(32'h0000_0003, 32'hFFFF_FFFF, 1'b1);
    acc_clr_i = 1'b1;
    step(1);
    acc_clr_i = 1'b0;
    send(32'h0000_0001, 32'h0, 1'b1);
    wait_results(3);
    n_checks++;
    if (q.size() > 0 && q[0] !== {1'b0, 2'b00, 32'h0000_0005}) begin
      n_fail++;
      $display("FAIL clr_prime: got %h required %h", q[0], {1'b0, 2'b00, 32'h0000_0005});
    end
    n_checks++;
    if (q.size() > 1 && q[1] !== {1'b0, 2'b00, 32'h0000_0003}) begin
      n_fail++;
      $display("FAIL clr_collision: got %h required %h", q[1], {1'b0, 2'b00, 32'h0000_0003});
    end
    n_checks++;
    if (q.size() > 2 && q[2] !== {1'b0, 2'b00, 32'h0000_0004}) begin
      n_fail++;
      $display("FAIL clr_acc_after: got %h required %h", q[2], {1'b0, 2'b00, 32'h0000_0004});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    mode_i    = 1'b0;
    acc_clr_i = 1'b0;
    a_i       = '0;
    b_i       = '0;
    out_ready = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    test_reset();
    test_mode0();
    test_both_carry();
    test_accumulate();
    test_backpressure();
    test_clr_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
